// File: rtl/tty_pkg.sv
// rtl/tty_pkg.sv - shared types and constants for the TTY UART transmitter
package tty_pkg;

    localparam int TTY_DATA_W      = 7;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tty_tx_state_t;

endpackage

// File: rtl/tty_uart_tx_sync_fifo.sv
// rtl/tty_uart_tx_sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    // Full and empty come straight from the registered level, so a pop in the
    // same cycle never makes room for a write that arrives against a full FIFO.
    assign full_o    = (level == FULL_LVL);
    assign empty_o   = (level == '0);
    assign level_o   = level;
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign rd_data_o = mem[rd_ptr];

    // Storage array; no reset needed since entries are only read when level is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push/pop balance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tty_uart_tx.sv
// rtl/tty_uart_tx.sv - buffered 8N1 UART transmitter for the MCU TTY port
module tty_uart_tx
    import tty_pkg::*;
#(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [TTY_DATA_W-1:0]         tty_data_i,
    input  logic                          tty_we_i,
    input  logic                          ovf_clr_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          full_o,
    output logic                          ovf_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_FRAME_BITS - 3);

    tty_tx_state_t              state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 bit_q, bit_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       ovf_q;
    logic                       pop;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [TTY_DATA_W-1:0]      fifo_rd;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                       bit_end;

    sync_fifo #(
        .WIDTH (TTY_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (tty_we_i),
        .wr_data_i (tty_data_i),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign bit_end = (cnt_q == '0);

    // Next-state logic: frame sequencing, baud countdown, shifting and FIFO pops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = {1'b0, fifo_rd};
                    cnt_d   = CNT_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = CNT_LOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = CNT_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = {1'b0, fifo_rd};
                        cnt_d   = CNT_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset drops the line back to idle-high at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Sticky drop flag; a drop in the same cycle wins over a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (tty_we_i && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = (state_q != IDLE) | (fifo_level != '0);
    assign full_o  = fifo_full;
    assign ovf_o   = ovf_q;
    assign level_o = fifo_level;

endmodule
